// File: rtl/vidmode_lock_ctrl_pkg.sv
// Shared video definitions for the mode-lock controller: the state encoding
// seen on o_state and the default widths of mode dimensions and counters.
package vidmode_lock_ctrl_pkg;

    localparam int VID_LGDIM    = 16;
    localparam int VID_LGSTABLE = 4;
    localparam int VID_LGLOST   = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_QUALIFY = 2'd1,
        ST_RUN     = 2'd2,
        ST_STOP    = 2'd3
    } vid_lock_state_e;

endpackage

// File: rtl/vidmode_lock_ctrl.sv
// Video mode lock controller. Watches the sync measurer and waits for a run of
// identical locked frames, then latches the mode and opens the pixel stream.
// Lock loss or a mode change while streaming closes the gate, counts the loss
// and raises an interrupt. A software disable lets the frame in flight finish.
module vidmode_lock_ctrl
    import vidmode_lock_ctrl_pkg::*;
#(
    parameter int LGDIM    = VID_LGDIM,
    parameter int LGSTABLE = VID_LGSTABLE
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_cfg_enable,
    input  logic [LGSTABLE-1:0] i_cfg_frames,
    input  logic                i_locked,
    input  logic [LGDIM-1:0]    i_width,
    input  logic [LGDIM-1:0]    i_height,
    input  logic [LGDIM-1:0]    i_raw_width,
    input  logic [LGDIM-1:0]    i_raw_height,
    input  logic                i_frame_end,
    output logic                o_stream_en,
    output logic                o_mode_valid,
    output logic [LGDIM-1:0]    o_width,
    output logic [LGDIM-1:0]    o_height,
    output logic [LGDIM-1:0]    o_raw_width,
    output logic [LGDIM-1:0]    o_raw_height,
    output logic                o_int_change,
    output logic [15:0]         o_lost_count,
    output logic [1:0]          o_state
);

    localparam logic [LGSTABLE-1:0]   CNT_MAX  = {LGSTABLE{1'b1}};
    localparam logic [LGSTABLE-1:0]   CNT_ONE  = LGSTABLE'(1);
    localparam logic [VID_LGLOST-1:0] LOST_MAX = {VID_LGLOST{1'b1}};

    vid_lock_state_e state_q, state_d;

    logic [LGSTABLE-1:0]   cnt_q, cnt_d;

    logic [LGDIM-1:0]      snap_w_q, snap_w_d;
    logic [LGDIM-1:0]      snap_h_q, snap_h_d;
    logic [LGDIM-1:0]      snap_rw_q, snap_rw_d;
    logic [LGDIM-1:0]      snap_rh_q, snap_rh_d;

    logic [LGDIM-1:0]      mode_w_q, mode_w_d;
    logic [LGDIM-1:0]      mode_h_q, mode_h_d;
    logic [LGDIM-1:0]      mode_rw_q, mode_rw_d;
    logic [LGDIM-1:0]      mode_rh_q, mode_rh_d;

    logic                  stream_en_q, stream_en_d;
    logic                  mode_valid_q, mode_valid_d;
    logic                  int_change_q, int_change_d;
    logic [VID_LGLOST-1:0] lost_q, lost_d;

    logic                  snap_match;
    logic                  mode_match;
    logic                  lose_lock;
    logic [LGSTABLE-1:0]   cnt_bump;
    logic [LGSTABLE-1:0]   qual_cnt;
    logic [LGSTABLE-1:0]   cfg_thresh;
    logic [VID_LGLOST-1:0] lost_bump;

    // Incoming mode against the qualification snapshot and the latched mode.
    assign snap_match = (i_width     == snap_w_q)  && (i_height     == snap_h_q) &&
                        (i_raw_width == snap_rw_q) && (i_raw_height == snap_rh_q);
    assign mode_match = (i_width     == mode_w_q)  && (i_height     == mode_h_q) &&
                        (i_raw_width == mode_rw_q) && (i_raw_height == mode_rh_q);

    // While streaming, either lock loss or a drifted mode ends the run.
    assign lose_lock  = !i_locked || !mode_match;

    // Stable counter never wraps; a changed mode restarts the run at one frame.
    assign cnt_bump   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    assign qual_cnt   = snap_match ? cnt_bump : CNT_ONE;

    // A zero frame requirement behaves like one frame.
    assign cfg_thresh = (i_cfg_frames == '0) ? CNT_ONE : i_cfg_frames;

    assign lost_bump  = (lost_q == LOST_MAX) ? lost_q : lost_q + VID_LGLOST'(1);

    // Next-state and registered-output decisions; lock loss outranks disable,
    // which outranks frame end.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        snap_w_d     = snap_w_q;
        snap_h_d     = snap_h_q;
        snap_rw_d    = snap_rw_q;
        snap_rh_d    = snap_rh_q;
        mode_w_d     = mode_w_q;
        mode_h_d     = mode_h_q;
        mode_rw_d    = mode_rw_q;
        mode_rh_d    = mode_rh_q;
        stream_en_d  = stream_en_q;
        mode_valid_d = mode_valid_q;
        int_change_d = 1'b0;
        lost_d       = lost_q;

        case (state_q)
            ST_IDLE: begin
                if (i_cfg_enable) begin
                    state_d = ST_QUALIFY;
                    cnt_d   = '0;
                end
            end

            ST_QUALIFY: begin
                if (!i_cfg_enable) begin
                    state_d = ST_IDLE;
                end else if (i_frame_end) begin
                    if (i_locked) begin
                        cnt_d = qual_cnt;
                        if (!snap_match) begin
                            snap_w_d  = i_width;
                            snap_h_d  = i_height;
                            snap_rw_d = i_raw_width;
                            snap_rh_d = i_raw_height;
                        end
                        // The snapshot after this frame always equals the
                        // incoming mode, so the incoming mode is latched.
                        if (qual_cnt >= cfg_thresh) begin
                            mode_w_d     = i_width;
                            mode_h_d     = i_height;
                            mode_rw_d    = i_raw_width;
                            mode_rh_d    = i_raw_height;
                            stream_en_d  = 1'b1;
                            mode_valid_d = 1'b1;
                            int_change_d = 1'b1;
                            state_d      = ST_RUN;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
            end

            ST_RUN: begin
                if (lose_lock) begin
                    stream_en_d  = 1'b0;
                    mode_valid_d = 1'b0;
                    int_change_d = 1'b1;
                    lost_d       = lost_bump;
                    cnt_d        = '0;
                    state_d      = ST_QUALIFY;
                end else if (!i_cfg_enable) begin
                    state_d = ST_STOP;
                end
            end

            ST_STOP: begin
                if (lose_lock) begin
                    stream_en_d  = 1'b0;
                    mode_valid_d = 1'b0;
                    int_change_d = 1'b1;
                    lost_d       = lost_bump;
                    cnt_d        = '0;
                    state_d      = ST_IDLE;
                end else if (i_frame_end) begin
                    stream_en_d  = 1'b0;
                    mode_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset to an all-clear idle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            snap_w_q     <= '0;
            snap_h_q     <= '0;
            snap_rw_q    <= '0;
            snap_rh_q    <= '0;
            mode_w_q     <= '0;
            mode_h_q     <= '0;
            mode_rw_q    <= '0;
            mode_rh_q    <= '0;
            stream_en_q  <= 1'b0;
            mode_valid_q <= 1'b0;
            int_change_q <= 1'b0;
            lost_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            snap_w_q     <= snap_w_d;
            snap_h_q     <= snap_h_d;
            snap_rw_q    <= snap_rw_d;
            snap_rh_q    <= snap_rh_d;
            mode_w_q     <= mode_w_d;
            mode_h_q     <= mode_h_d;
            mode_rw_q    <= mode_rw_d;
            mode_rh_q    <= mode_rh_d;
            stream_en_q  <= stream_en_d;
            mode_valid_q <= mode_valid_d;
            int_change_q <= int_change_d;
            lost_q       <= lost_d;
        end
    end

    assign o_stream_en  = stream_en_q;
    assign o_mode_valid = mode_valid_q;
    assign o_width      = mode_w_q;
    assign o_height     = mode_h_q;
    assign o_raw_width  = mode_rw_q;
    assign o_raw_height = mode_rh_q;
    assign o_int_change = int_change_q;
    assign o_lost_count = lost_q;
    assign o_state      = state_q;

endmodule

// File: tb/tb_vidmode_lock_ctrl.sv
// Directed bench for the video mode lock controller. Each step drives inputs
// on the falling edge, predicts the registered outputs with a behavioural
// model and queues the prediction; the entry is popped and compared on the
// following falling edge.
module tb_vidmode_lock_ctrl;

    logic        clk;
    logic        reset;
    logic        cfgEnable;
    logic [3:0]  cfgFrames;
    logic        locked;
    logic [15:0] inW, inH, inRawW, inRawH;
    logic        frameEnd;

    logic        streamEn;
    logic        modeValid;
    logic [15:0] outW, outH, outRawW, outRawH;
    logic        intChange;
    logic [15:0] lostCount;
    logic [1:0]  stateOut;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  state;
        logic        streamEn;
        logic        modeValid;
        logic        intChange;
        logic [15:0] lost;
        logic [15:0] w, h, rw, rh;
    } expect_t;

    expect_t expQ[$];

    logic [1:0]  mState = 2'd0;
    logic [3:0]  mCnt   = 4'd0;
    logic [15:0] mSnapW = 16'd0, mSnapH = 16'd0, mSnapRw = 16'd0, mSnapRh = 16'd0;
    logic [15:0] mOutW  = 16'd0, mOutH  = 16'd0, mOutRw  = 16'd0, mOutRh  = 16'd0;
    logic        mEn    = 1'b0;
    logic        mMv    = 1'b0;
    logic        mInt   = 1'b0;
    logic [15:0] mLost  = 16'd0;

    vidmode_lock_ctrl dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_cfg_enable (cfgEnable),
        .i_cfg_frames (cfgFrames),
        .i_locked     (locked),
        .i_width      (inW),
        .i_height     (inH),
        .i_raw_width  (inRawW),
        .i_raw_height (inRawH),
        .i_frame_end  (frameEnd),
        .o_stream_en  (streamEn),
        .o_mode_valid (modeValid),
        .o_width      (outW),
        .o_height     (outH),
        .o_raw_width  (outRawW),
        .o_raw_height (outRawH),
        .o_int_change (intChange),
        .o_lost_count (lostCount),
        .o_state      (stateOut)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Behavioural prediction of the outputs after the coming rising edge.
    task automatic modelStep();
        logic       lossEv;
        logic [3:0] thr;
        mInt   = 1'b0;
        lossEv = !locked || (inW != mOutW) || (inH != mOutH) ||
                 (inRawW != mOutRw) || (inRawH != mOutRh);
        if (reset) begin
            mState = 2'd0; mCnt = 4'd0; mEn = 1'b0; mMv = 1'b0; mLost = 16'd0;
            mSnapW = 16'd0; mSnapH = 16'd0; mSnapRw = 16'd0; mSnapRh = 16'd0;
            mOutW  = 16'd0; mOutH  = 16'd0; mOutRw  = 16'd0; mOutRh  = 16'd0;
        end else begin
            case (mState)
                2'd0: begin
                    if (cfgEnable) begin
                        mState = 2'd1;
                        mCnt   = 4'd0;
                    end
                end
                2'd1: begin
                    if (!cfgEnable) begin
                        mState = 2'd0;
                    end else if (frameEnd && !locked) begin
                        mCnt = 4'd0;
                    end else if (frameEnd) begin
                        if (inW == mSnapW && inH == mSnapH && inRawW == mSnapRw && inRawH == mSnapRh) begin
                            if (mCnt != 4'hF) mCnt = mCnt + 4'd1;
                        end else begin
                            mSnapW = inW; mSnapH = inH; mSnapRw = inRawW; mSnapRh = inRawH;
                            mCnt = 4'd1;
                        end
                        thr = (cfgFrames == 4'd0) ? 4'd1 : cfgFrames;
                        if (mCnt >= thr) begin
                            mOutW = mSnapW; mOutH = mSnapH; mOutRw = mSnapRw; mOutRh = mSnapRh;
                            mEn = 1'b1; mMv = 1'b1; mInt = 1'b1;
                            mState = 2'd2;
                        end
                    end
                end
                default: begin
                    if (lossEv) begin
                        mEn = 1'b0; mMv = 1'b0; mInt = 1'b1; mCnt = 4'd0;
                        if (mLost != 16'hFFFF) mLost = mLost + 16'd1;
                        mState = (mState == 2'd2) ? 2'd1 : 2'd0;
                    end else if (mState == 2'd2 && !cfgEnable) begin
                        mState = 2'd3;
                    end else if (mState == 2'd3 && frameEnd) begin
                        mEn = 1'b0; mMv = 1'b0;
                        mState = 2'd0;
                    end
                end
            endcase
        end
    endtask

    task automatic compareField(input string tag, input logic [31:0] observed, input logic [31:0] expVal);
        checks++;
        assert (observed === expVal)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expVal);
        end
    endtask

    task automatic applyStimulus(input logic fe);
        expect_t e;
        frameEnd = fe;
        modelStep();
        e.state     = mState;
        e.streamEn  = mEn;
        e.modeValid = mMv;
        e.intChange = mInt;
        e.lost      = mLost;
        e.w  = mOutW;  e.h  = mOutH;
        e.rw = mOutRw; e.rh = mOutRh;
        expQ.push_back(e);
    endtask

    task automatic checkOutput();
        expect_t e;
        @(posedge clk);
        @(negedge clk);
        checks++;
        assert (expQ.size() != 0)
        else begin
            errors++;
            $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
        end
        if (expQ.size() != 0) begin
            e = expQ.pop_front();
            compareField("state",       32'(stateOut),  32'(e.state));
            compareField("stream_en",   32'(streamEn),  32'(e.streamEn));
            compareField("mode_valid",  32'(modeValid), 32'(e.modeValid));
            compareField("int_change",  32'(intChange), 32'(e.intChange));
            compareField("lost_count",  32'(lostCount), 32'(e.lost));
            compareField("width",       32'(outW),      32'(e.w));
            compareField("height",      32'(outH),      32'(e.h));
            compareField("raw_width",   32'(outRawW),   32'(e.rw));
            compareField("raw_height",  32'(outRawH),   32'(e.rh));
        end
    endtask

    task automatic step(input logic fe);
        applyStimulus(fe);
        checkOutput();
    endtask

    // A frame of len cycles whose last cycle carries the frame-end pulse.
    task automatic runFrame(input int len);
        for (int i = 0; i < len - 1; i++) step(1'b0);
        step(1'b1);
    endtask

    task automatic setMode(input logic [15:0] w, input logic [15:0] h,
                           input logic [15:0] rw, input logic [15:0] rh);
        inW = w; inH = h; inRawW = rw; inRawH = rh;
    endtask

    // One qualify-to-run entry followed by a lock drop back to qualify.
    task automatic lossRound();
        locked = 1'b1;
        step(1'b1);
        locked = 1'b0;
        step(1'b0);
        locked = 1'b1;
    endtask

    initial begin
        reset     = 1'b1;
        cfgEnable = 1'b0;
        cfgFrames = 4'd3;
        locked    = 1'b0;
        frameEnd  = 1'b0;
        setMode(16'd1920, 16'd1080, 16'd2200, 16'd1125);

        // Reset clears everything even with a live mode on the inputs.
        step(1'b0);
        step(1'b0);
        compareField("reset_state", 32'(stateOut),  32'd0);
        compareField("reset_lost",  32'(lostCount), 32'd0);
        compareField("reset_width", 32'(outW),      32'd0);

        // 1080p qualifies after three identical locked frames.
        reset     = 1'b0;
        locked    = 1'b1;
        cfgEnable = 1'b1;
        step(1'b0);
        compareField("enable_to_qualify", 32'(stateOut), 32'd1);
        runFrame(4);
        runFrame(4);
        compareField("two_frames_still_qualify", 32'(stateOut), 32'd1);
        runFrame(4);
        compareField("run_state",      32'(stateOut),  32'd2);
        compareField("run_stream_en",  32'(streamEn),  32'd1);
        compareField("run_int",        32'(intChange), 32'd1);
        compareField("run_width",      32'(outW),      32'd1920);
        compareField("run_height",     32'(outH),      32'd1080);
        compareField("run_raw_width",  32'(outRawW),   32'd2200);
        compareField("run_raw_height", 32'(outRawH),   32'd1125);
        step(1'b0);
        compareField("int_one_cycle", 32'(intChange), 32'd0);

        // Lock drops mid-frame while running.
        locked = 1'b0;
        step(1'b0);
        compareField("loss_stream_en", 32'(streamEn),  32'd0);
        compareField("loss_count",     32'(lostCount), 32'd1);
        compareField("loss_int",       32'(intChange), 32'd1);
        compareField("loss_state",     32'(stateOut),  32'd1);
        locked = 1'b1;

        // A 1280 frame mid-qualification restarts the run of stable frames.
        runFrame(3);
        setMode(16'd1280, 16'd720, 16'd1650, 16'd750);
        runFrame(3);
        runFrame(3);
        compareField("restart_still_qualify", 32'(stateOut), 32'd1);
        runFrame(3);
        compareField("restart_run_state", 32'(stateOut), 32'd2);
        compareField("restart_width",     32'(outW),     32'd1280);

        // Disable mid-frame: stream stays open until the frame completes.
        step(1'b0);
        cfgEnable = 1'b0;
        step(1'b0);
        compareField("stop_state",     32'(stateOut), 32'd3);
        compareField("stop_stream_en", 32'(streamEn), 32'd1);
        step(1'b0);
        step(1'b0);
        compareField("stop_hold_stream_en", 32'(streamEn), 32'd1);
        step(1'b1);
        compareField("stop_end_stream_en", 32'(streamEn), 32'd0);
        compareField("stop_end_state",     32'(stateOut), 32'd0);
        compareField("dims_hold",          32'(outW),     32'd1280);

        // Disable during qualification returns to idle quietly.
        cfgEnable = 1'b1;
        step(1'b0);
        runFrame(3);
        cfgEnable = 1'b0;
        step(1'b0);
        compareField("qualify_abort_state", 32'(stateOut),  32'd0);
        compareField("qualify_abort_int",   32'(intChange), 32'd0);

        // A zero frame requirement behaves as one frame.
        cfgFrames = 4'd0;
        cfgEnable = 1'b1;
        step(1'b0);
        runFrame(2);
        compareField("zero_frames_run", 32'(stateOut), 32'd2);

        // Locked but the height drifts while running.
        setMode(16'd1280, 16'd1024, 16'd1650, 16'd750);
        step(1'b0);
        compareField("mismatch_state", 32'(stateOut),  32'd1);
        compareField("mismatch_lost",  32'(lostCount), 32'd2);

        // Disable and lock loss together take the lock-loss path.
        cfgFrames = 4'd1;
        runFrame(2);
        compareField("new_mode_height", 32'(outH), 32'd1024);
        cfgEnable = 1'b0;
        locked    = 1'b0;
        step(1'b0);
        compareField("both_state", 32'(stateOut),  32'd1);
        compareField("both_lost",  32'(lostCount), 32'd3);
        compareField("both_int",   32'(intChange), 32'd1);
        locked = 1'b1;
        step(1'b0);

        // Lock loss while stopping goes straight to idle.
        cfgEnable = 1'b1;
        step(1'b0);
        step(1'b1);
        cfgEnable = 1'b0;
        step(1'b0);
        locked = 1'b0;
        step(1'b0);
        compareField("stop_loss_state", 32'(stateOut),  32'd0);
        compareField("stop_loss_lost",  32'(lostCount), 32'd4);
        locked = 1'b1;

        // Reset mid-frame while running closes the stream without a loss.
        cfgEnable = 1'b1;
        step(1'b0);
        step(1'b1);
        step(1'b0);
        reset = 1'b1;
        step(1'b0);
        compareField("reset_run_stream_en", 32'(streamEn),  32'd0);
        compareField("reset_run_lost",      32'(lostCount), 32'd0);
        reset = 1'b0;

        // Loss counter: a few real losses, then preload near the top so
        // saturation is reached after a handful more.
        step(1'b0);
        for (int i = 0; i < 3; i++) lossRound();
        compareField("lost_three", 32'(lostCount), 32'd3);
        force dut.lost_q = 16'hFFFD;
        mLost = 16'hFFFD;
        step(1'b0);
        release dut.lost_q;
        for (int i = 0; i < 5; i++) lossRound();
        compareField("lost_saturated", 32'(lostCount), 32'hFFFF);
        reset = 1'b1;
        step(1'b0);
        compareField("lost_cleared", 32'(lostCount), 32'd0);
        reset = 1'b0;
        step(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
